ssd_display_ctrl: RTL and testbench

Four-digit seven-segment display controller that sits directly downstream of the core datapath. It takes the 13-bit value the core selects with `ssdSel`, converts it from binary to four BCD digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto the board's common-anode display through `Anode` and `LED_out`.

---
 rtl/ssd_display_ctrl.sv | 134 +++++++++++++
 tb/tb_ssd_display_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ssd_display_ctrl.sv
// Four-digit seven-segment controller: sequential double-dabble BCD conversion plus multiplexed scan.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits (units always shown).
module ssd_display_ctrl #(
    parameter int REFRESH_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] num,
    input  logic        load,
    output logic        busy,
    output logic [3:0]  Anode,
    output logic [6:0]  LED_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                  r_state, w_stateNext;
    logic [12:0]             r_bin, w_binNext;
    logic [15:0]             r_bcd, w_bcdNext, w_bcdAdj;
    logic [3:0]              r_cnt, w_cntNext;
    logic [15:0]             r_digits, w_digitsNext;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic [3:0]              r_anode, w_anodeNext;
    logic [6:0]              r_led, w_ledNext;
    logic [1:0]              w_sel;
    logic [3:0]              w_digit;
    logic                    w_blank;

    assign busy    = (r_state != IDLE);
    assign Anode   = r_anode;
    assign LED_out = r_led;
    assign w_sel   = r_refresh[REFRESH_BITS-1 -: 2];

    // Add-3 correction is applied to every nibble before each shift.
    always_comb begin
        w_bcdAdj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcdAdj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_binNext    = r_bin;
        w_bcdNext    = r_bcd;
        w_cntNext    = r_cnt;
        w_digitsNext = r_digits;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_binNext   = num;
                    w_bcdNext   = 16'd0;
                    w_cntNext   = 4'd13;
                    w_stateNext = SHIFT;
                end
            end
            SHIFT: begin
                {w_bcdNext, w_binNext} = {w_bcdAdj[14:0], r_bin, 1'b0};
                w_cntNext = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_stateNext = COMMIT;
                end
            end
            COMMIT: begin
                w_digitsNext = r_bcd;
                w_stateNext  = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        w_anodeNext = 4'b1111;
        w_digit     = 4'd0;
        w_blank     = 1'b0;
        case (w_sel)
            2'd0: begin w_anodeNext = 4'b0111; w_digit = r_digits[15:12]; end
            2'd1: begin w_anodeNext = 4'b1011; w_digit = r_digits[11:8];  end
            2'd2: begin w_anodeNext = 4'b1101; w_digit = r_digits[7:4];   end
            default: begin w_anodeNext = 4'b1110; w_digit = r_digits[3:0]; end
        endcase
`ifdef SSD_LEADING_ZERO_BLANK_EN
        case (w_sel)
            2'd0:    w_blank = (r_digits[15:12] == 4'd0);
            2'd1:    w_blank = (r_digits[15:8] == 8'd0);
            2'd2:    w_blank = (r_digits[15:4] == 12'd0);
            default: w_blank = 1'b0;
        endcase
`else
        w_blank = 1'b0;
`endif
        case (w_digit)
            4'd0: w_ledNext = 7'b0000001;
            4'd1: w_ledNext = 7'b1001111;
            4'd2: w_ledNext = 7'b0010010;
            4'd3: w_ledNext = 7'b0000110;
            4'd4: w_ledNext = 7'b1001100;
            4'd5: w_ledNext = 7'b0100100;
            4'd6: w_ledNext = 7'b0100000;
            4'd7: w_ledNext = 7'b0001111;
            4'd8: w_ledNext = 7'b0000000;
            4'd9: w_ledNext = 7'b0000100;
            default: w_ledNext = 7'b1111111;
        endcase
        if (w_blank) begin
            w_ledNext = 7'b1111111;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_bin     <= 13'd0;
            r_bcd     <= 16'd0;
            r_cnt     <= 4'd0;
            r_digits  <= 16'd0;
            r_refresh <= '0;
            r_anode   <= 4'b1111;
            r_led     <= 7'b1111111;
        end else begin
            r_state   <= w_stateNext;
            r_bin     <= w_binNext;
            r_bcd     <= w_bcdNext;
            r_cnt     <= w_cntNext;
            r_digits  <= w_digitsNext;
            r_refresh <= r_refresh + 1'b1;
            r_anode   <= w_anodeNext;
            r_led     <= w_ledNext;
        end
    end

endmodule

// File: tb/tb_ssd_display_ctrl.sv
// Directed bench for ssd_display_ctrl with REFRESH_BITS=4; tracks the refresh phase with its own cycle counter.
module tb_ssd_display_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [12:0] num = 13'd0;
    logic        load = 1'b0;
    logic        busy;
    logic [3:0]  Anode;
    logic [6:0]  LED_out;

    int          assertCount = 0;
    int          failCount = 0;
    int          cyc = 0;
    int          n;
    logic [15:0] expDigits = 16'h0000;

    ssd_display_ctrl #(.REFRESH_BITS(4)) dut (
        .clk(clk), .rst(rst), .num(num), .load(load),
        .busy(busy), .Anode(Anode), .LED_out(LED_out)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; cycle c shows the digit chosen by refresh value c-1.
    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] segOf(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] expAnode(input int c);
        if (c == 0) return 4'b1111;
        case (((c - 1) >> 2) & 3)
            0: return 4'b0111;
            1: return 4'b1011;
            2: return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [6:0] expLed(input logic [15:0] d, input int c);
        int s;
        logic [3:0] nib;
        logic blank;
        if (c == 0) return 7'b1111111;
        s = ((c - 1) >> 2) & 3;
        nib = d[(3 - s) * 4 +: 4];
        blank = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (s == 0)      blank = (d[15:12] == 4'd0);
        else if (s == 1) blank = (d[15:8] == 8'd0);
        else if (s == 2) blank = (d[15:4] == 12'd0);
`endif
        if (blank) return 7'b1111111;
        return segOf(nib);
    endfunction

    // Entered at a negedge; returns at the negedge where busy has just fallen.
    task automatic applyStimulus(input logic [12:0] value);
        num  = value;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checkOutput("busyLen", 16'(n), 16'd14);
    endtask

    task automatic scanCheck(input string tag, input int cycles);
        @(negedge clk);
        for (int i = 0; i < cycles; i++) begin
            checkOutput({tag, "_anode"}, {12'd0, Anode}, {12'd0, expAnode(cyc)});
            checkOutput({tag, "_seg"}, {9'd0, LED_out}, {9'd0, expLed(expDigits, cyc)});
            checkOutput({tag, "_oneLow"}, 16'($countones(~Anode)), 16'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rstAnode", {12'd0, Anode}, 16'h000F);
        checkOutput("rstLed", {9'd0, LED_out}, 16'h007F);
        checkOutput("rstBusy", {15'd0, busy}, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("firstAnode", {12'd0, Anode}, 16'h0007);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        checkOutput("firstLed", {9'd0, LED_out}, 16'h007F);
`else
        checkOutput("firstLed", {9'd0, LED_out}, 16'h0001);
`endif

        applyStimulus(13'd1234);
        expDigits = 16'h1234;
        scanCheck("d1234", 16);

        applyStimulus(13'd8191);
        expDigits = 16'h8191;
        scanCheck("d8191", 16);

        applyStimulus(13'd0);
        expDigits = 16'h0000;
        scanCheck("d0", 16);

        // 42 with loads at SHIFT cycle 3 and at COMMIT, both ignored
        num = 13'd42;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checkOutput("busyRise", {15'd0, busy}, 16'd1);
        repeat (2) @(negedge clk);
        num = 13'd99;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checkOutput("busyMid", {15'd0, busy}, 16'd1);
        repeat (10) @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checkOutput("busyFall", {15'd0, busy}, 16'd0);
        @(negedge clk);
        checkOutput("commitLoadIgnored", {15'd0, busy}, 16'd0);
        expDigits = 16'h0042;
        scanCheck("d42", 16);

        // load on the first idle cycle is accepted
        applyStimulus(13'd321);
        num = 13'd99;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checkOutput("firstIdleLoad", {15'd0, busy}, 16'd1);
        n = 1;
        @(negedge clk);
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checkOutput("busyLen99", 16'(n), 16'd14);
        expDigits = 16'h0099;
        scanCheck("d99", 16);

        // reset sampled at SHIFT cycle 7 discards the conversion
        num = 13'd5000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midRstBusy", {15'd0, busy}, 16'd0);
        checkOutput("midRstAnode", {12'd0, Anode}, 16'h000F);
        checkOutput("midRstLed", {9'd0, LED_out}, 16'h007F);
        rst = 1'b1;
        expDigits = 16'h0000;
        scanCheck("afterRst", 16);

        applyStimulus(13'd7);
        expDigits = 16'h0007;
        scanCheck("d7", 16);

        scanCheck("wrap", 64);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
